// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, parity modes and baud helper for the UART RX side
package uart_pkg;

  // Receiver states; prefixed so they never collide with module parameters
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // System clocks per UART bit (integer division, truncating)
  function automatic int bps_cnt(input int clk_freq, input int bps);
    return clk_freq / bps;
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// rtl/uart_rx_frame_if.sv - serial input and received-byte bundle of the UART receiver
interface uart_rx_frame_if;

  logic       uart_rxd;
  logic       uart_done;
  logic [7:0] uart_data;
  logic       parity_err;
  logic       frame_err;
  logic       rx_busy;

  // Line driver / byte consumer side
  modport master (
    output uart_rxd,
    input  uart_done,
    input  uart_data,
    input  parity_err,
    input  frame_err,
    input  rx_busy
  );

  // Receiver side
  modport slave (
    input  uart_rxd,
    output uart_done,
    output uart_data,
    output parity_err,
    output frame_err,
    output rx_busy
  );

endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer with falling-edge detect, idles high
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rxd_i,
  output logic rxd_s_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Resync the async line and keep one extra stage for edge detection; reset to idle level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rxd_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rxd_s_o = sync_q;
  assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - UART frame receiver with parity, framing and break/glitch handling
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int UART_BPS = 9600,
  parameter int PARITY   = PAR_NONE
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  uart_rx_frame_if.slave  rx_if
);

  localparam int BPS_CNT = bps_cnt(CLK_FREQ, UART_BPS);
  localparam int CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(BPS_CNT / 2 - 1);

  // Too few clocks per bit leaves no room for a mid-bit sample point
  if (BPS_CNT < 4) begin : g_bps_check
    $fatal(1, "uart_rx_frame: CLK_FREQ/UART_BPS must be at least 4");
  end
  if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_par_check
    $fatal(1, "uart_rx_frame: PARITY must be 0, 1 or 2");
  end

  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             par_mis_q, par_mis_d;
  logic             done_q, done_d;
  logic             ferr_q, ferr_d;
  logic             perr_q, perr_d;

  logic rxd_s;
  logic fall;
  logic mid_pt;
  logic bit_end;

  uart_rx_sync u_sync (
    .clk_i   (sys_clk),
    .rst_i   (sys_rst),
    .rxd_i   (rx_if.uart_rxd),
    .rxd_s_o (rxd_s),
    .fall_o  (fall)
  );

  assign mid_pt  = (clk_cnt_q == CNT_MID);
  assign bit_end = (clk_cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: half a bit into the start bit, then one full bit per field
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (fall) state_d = ST_START;
      ST_START:  if (mid_pt) state_d = rxd_s ? ST_IDLE : ST_DATA;
      ST_DATA: begin
        if (bit_end && bit_cnt_q == 3'd7) begin
          state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: if (bit_end) state_d = ST_STOP;
      ST_STOP:   if (bit_end) state_d = rxd_s ? ST_IDLE : ST_BREAK;
      ST_BREAK:  if (rxd_s) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values; pulses default low every cycle
  always_comb begin
    clk_cnt_d = '0;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_mis_d = par_mis_q;
    data_d    = data_q;
    done_d    = 1'b0;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;
    case (state_q)
      ST_START: begin
        // Restart the timer at the start-bit centre so later samples land mid-bit
        clk_cnt_d = mid_pt ? '0 : clk_cnt_q + 1'b1;
        bit_cnt_d = '0;
        par_mis_d = 1'b0;
      end
      ST_DATA: begin
        clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
        if (bit_end) begin
          shift_d[bit_cnt_q] = rxd_s;
          bit_cnt_d          = bit_cnt_q + 3'd1;
        end
      end
      ST_PARITY: begin
        clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
        if (bit_end) begin
          par_mis_d = (PARITY == PAR_ODD) ? ~(^shift_q ^ rxd_s) : (^shift_q ^ rxd_s);
        end
      end
      ST_STOP: begin
        clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
        if (bit_end) begin
          if (rxd_s) begin
            data_d = shift_q;
            done_d = 1'b1;
            perr_d = par_mis_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: clk_cnt_d = '0;
    endcase
  end

  // Datapath registers; reset aborts any frame in flight without pulses
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_mis_q <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_mis_q <= par_mis_d;
      data_q    <= data_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
    end
  end

  assign rx_if.uart_done  = done_q;
  assign rx_if.uart_data  = data_q;
  assign rx_if.parity_err = perr_q;
  assign rx_if.frame_err  = ferr_q;
  assign rx_if.rx_busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - scoreboard bench for uart_rx_frame in none/odd/even parity modes
module tb_uart_rx_frame;

  localparam int BPS = 10;
  // done appears the cycle after the stop-bit sample: line-drive cycle N gives
  // edge flag t0 = N+2 and done at t0 + BPS/2 + (9+P)*BPS + 1 = N + 98 + 10*P
  localparam int DONE_LAT = 2 + BPS / 2 + 9 * BPS + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_frame_if if0 ();
  uart_rx_frame_if if1 ();
  uart_rx_frame_if if2 ();

  logic line_v = 1'b1;
  int   sel_v  = 0;
  assign if0.uart_rxd = (sel_v == 0) ? line_v : 1'b1;
  assign if1.uart_rxd = (sel_v == 1) ? line_v : 1'b1;
  assign if2.uart_rxd = (sel_v == 2) ? line_v : 1'b1;

  uart_rx_frame #(.CLK_FREQ(1000000), .UART_BPS(100000), .PARITY(0)) dut0 (
    .sys_clk(clk), .sys_rst(rst), .rx_if(if0));
  uart_rx_frame #(.CLK_FREQ(1000000), .UART_BPS(100000), .PARITY(1)) dut1 (
    .sys_clk(clk), .sys_rst(rst), .rx_if(if1));
  uart_rx_frame #(.CLK_FREQ(1000000), .UART_BPS(100000), .PARITY(2)) dut2 (
    .sys_clk(clk), .sys_rst(rst), .rx_if(if2));

  logic [2:0] done_w, perr_w, ferr_w, busy_w;
  logic [7:0] data_w [3];
  assign done_w = {if2.uart_done, if1.uart_done, if0.uart_done};
  assign perr_w = {if2.parity_err, if1.parity_err, if0.parity_err};
  assign ferr_w = {if2.frame_err, if1.frame_err, if0.frame_err};
  assign busy_w = {if2.rx_busy, if1.rx_busy, if0.rx_busy};
  assign data_w[0] = if0.uart_data;
  assign data_w[1] = if1.uart_data;
  assign data_w[2] = if2.uart_data;

  typedef struct packed {
    logic [7:0]  data;
    logic        perr;
    logic [31:0] due;
  } exp_t;

  exp_t exp_q [3][$];
  int   checks = 0;
  int   passed = 0;
  int   done_cnt [3] = '{0, 0, 0};
  int   ferr_cnt [3] = '{0, 0, 0};

  // Scoreboard: pop one expected frame per done pulse and check data, parity flag and timing
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (done_w[i]) begin
        done_cnt[i]++;
        if (exp_q[i].size() == 0) begin
          checks++;
          $display("FAIL unexpected_done dut%0d data=%h required=no pulse", i, data_w[i]);
        end else begin
          e = exp_q[i].pop_front();
          checks++;
          if (data_w[i] !== e.data) $display("FAIL sb_data dut%0d got=%h exp=%h", i, data_w[i], e.data);
          else passed++;
          checks++;
          if (perr_w[i] !== e.perr) $display("FAIL sb_parity_err dut%0d got=%b exp=%b", i, perr_w[i], e.perr);
          else passed++;
          checks++;
          if (cyc !== e.due) $display("FAIL sb_latency dut%0d got_cycle=%0d exp_cycle=%0d", i, cyc, e.due);
          else passed++;
        end
      end
      if (ferr_w[i]) ferr_cnt[i]++;
      if (done_w[i] && ferr_w[i]) begin
        checks++;
        $display("FAIL done_and_frame_err dut%0d got=both high required=exclusive", i);
      end
      if (perr_w[i] && !done_w[i]) begin
        checks++;
        $display("FAIL parity_err_unqualified dut%0d got=1 exp=0", i);
      end
    end
  end

  // Drive one frame starting at a negedge; optionally push the expected result
  task automatic send_frame(input int sel, input logic [7:0] d, input logic par_bit,
                            input logic stop_bit, input logic push);
    exp_t e;
    sel_v = sel;
    if (push) begin
      e.data = d;
      e.due  = cyc + DONE_LAT + ((sel != 0) ? BPS : 0);
      if (sel == 1)      e.perr = ~(^d ^ par_bit);
      else if (sel == 2) e.perr = ^d ^ par_bit;
      else               e.perr = 1'b0;
      exp_q[sel].push_back(e);
    end
    line_v = 1'b0;
    repeat (BPS) @(negedge clk);
    for (int b = 0; b < 8; b++) begin
      line_v = d[b];
      repeat (BPS) @(negedge clk);
    end
    if (sel != 0) begin
      line_v = par_bit;
      repeat (BPS) @(negedge clk);
    end
    line_v = stop_bit;
    repeat (BPS) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 400) $display("FAIL %s_drain got=%0d pending exp=0 pending", name,
                           exp_q[0].size() + exp_q[1].size() + exp_q[2].size());
    else passed++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++; if (done_w[i] !== 1'b0) $display("FAIL reset_done dut%0d got=%b exp=0", i, done_w[i]); else passed++;
      checks++; if (data_w[i] !== 8'h00) $display("FAIL reset_data dut%0d got=%h exp=00", i, data_w[i]); else passed++;
      checks++; if (perr_w[i] !== 1'b0) $display("FAIL reset_perr dut%0d got=%b exp=0", i, perr_w[i]); else passed++;
      checks++; if (ferr_w[i] !== 1'b0) $display("FAIL reset_ferr dut%0d got=%b exp=0", i, ferr_w[i]); else passed++;
      checks++; if (busy_w[i] !== 1'b0) $display("FAIL reset_busy dut%0d got=%b exp=0", i, busy_w[i]); else passed++;
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_single();
    int d0 = done_cnt[0];
    int f0 = ferr_cnt[0];
    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1);
    wait_drain("single");
    repeat (2) @(negedge clk);
    checks++; if (done_cnt[0] - d0 !== 1) $display("FAIL single_done_count got=%0d exp=1", done_cnt[0] - d0); else passed++;
    checks++; if (ferr_cnt[0] !== f0) $display("FAIL single_frame_err got=%0d exp=0", ferr_cnt[0] - f0); else passed++;
    checks++; if (if0.rx_busy !== 1'b0) $display("FAIL single_busy_after got=%b exp=0", if0.rx_busy); else passed++;
    checks++; if (if0.uart_data !== 8'hA5) $display("FAIL single_data_held got=%h exp=a5", if0.uart_data); else passed++;
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt[0];
    send_frame(0, 8'h00, 1'b0, 1'b1, 1'b1);
    send_frame(0, 8'hFF, 1'b0, 1'b1, 1'b1);
    wait_drain("b2b");
    repeat (2) @(negedge clk);
    checks++; if (done_cnt[0] - d0 !== 2) $display("FAIL b2b_done_count got=%0d exp=2", done_cnt[0] - d0); else passed++;
  endtask

  task automatic test_parity();
    int d1 = done_cnt[1];
    int d2 = done_cnt[2];
    send_frame(2, 8'h03, 1'b0, 1'b1, 1'b1);
    send_frame(2, 8'h03, 1'b1, 1'b1, 1'b1);
    repeat (BPS) @(negedge clk);
    send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1);
    send_frame(1, 8'h03, 1'b0, 1'b1, 1'b1);
    wait_drain("parity");
    repeat (2) @(negedge clk);
    checks++; if (done_cnt[2] - d2 !== 2) $display("FAIL even_done_count got=%0d exp=2", done_cnt[2] - d2); else passed++;
    checks++; if (done_cnt[1] - d1 !== 2) $display("FAIL odd_done_count got=%0d exp=2", done_cnt[1] - d1); else passed++;
    checks++; if (if2.uart_data !== 8'h03) $display("FAIL even_data_held got=%h exp=03", if2.uart_data); else passed++;
    checks++; if (if2.parity_err !== 1'b0) $display("FAIL even_perr_idle got=%b exp=0", if2.parity_err); else passed++;
    sel_v = 0;
    repeat (BPS) @(negedge clk);
  endtask

  task automatic test_break();
    int d0 = done_cnt[0];
    int f0 = ferr_cnt[0];
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    line_v = 1'b0;
    repeat (50) @(negedge clk);
    checks++; if (ferr_cnt[0] - f0 !== 1) $display("FAIL break_frame_err_count got=%0d exp=1", ferr_cnt[0] - f0); else passed++;
    checks++; if (if0.rx_busy !== 1'b1) $display("FAIL break_busy_low_line got=%b exp=1", if0.rx_busy); else passed++;
    checks++; if (if0.uart_data !== 8'hFF) $display("FAIL break_data_unchanged got=%h exp=ff", if0.uart_data); else passed++;
    line_v = 1'b1;
    repeat (2 * BPS) @(negedge clk);
    checks++; if (if0.rx_busy !== 1'b0) $display("FAIL break_exit_busy got=%b exp=0", if0.rx_busy); else passed++;
    send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1);
    wait_drain("break");
    repeat (2) @(negedge clk);
    checks++; if (done_cnt[0] - d0 !== 1) $display("FAIL break_done_count got=%0d exp=1", done_cnt[0] - d0); else passed++;
    checks++; if (ferr_cnt[0] - f0 !== 1) $display("FAIL break_frame_err_total got=%0d exp=1", ferr_cnt[0] - f0); else passed++;
  endtask

  task automatic test_glitch();
    int   d0 = done_cnt[0];
    int   f0 = ferr_cnt[0];
    logic seen = 1'b0;
    sel_v  = 0;
    line_v = 1'b0;
    repeat (3) @(negedge clk);
    line_v = 1'b1;
    for (int k = 0; k < BPS + 4; k++) begin
      @(negedge clk);
      if (if0.rx_busy) seen = 1'b1;
    end
    checks++; if (seen !== 1'b1) $display("FAIL glitch_busy_seen got=%b exp=1", seen); else passed++;
    checks++; if (if0.rx_busy !== 1'b0) $display("FAIL glitch_busy_after got=%b exp=0", if0.rx_busy); else passed++;
    checks++; if (done_cnt[0] !== d0) $display("FAIL glitch_done got=%0d exp=0", done_cnt[0] - d0); else passed++;
    checks++; if (ferr_cnt[0] !== f0) $display("FAIL glitch_frame_err got=%0d exp=0", ferr_cnt[0] - f0); else passed++;
  endtask

  task automatic test_reset_mid();
    int d0 = done_cnt[0];
    int f0 = ferr_cnt[0];
    sel_v  = 0;
    // Frame 8'hF0: start + four zero bits, then reset halfway through bit 4
    line_v = 1'b0;
    repeat (5 * BPS) @(negedge clk);
    line_v = 1'b1;
    repeat (BPS / 2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (if0.uart_data !== 8'h00) $display("FAIL rstmid_data got=%h exp=00", if0.uart_data); else passed++;
    checks++; if (if0.rx_busy !== 1'b0) $display("FAIL rstmid_busy got=%b exp=0", if0.rx_busy); else passed++;
    checks++; if ({if0.uart_done, if0.frame_err, if0.parity_err} !== 3'b000)
      $display("FAIL rstmid_pulses got=%b exp=000", {if0.uart_done, if0.frame_err, if0.parity_err}); else passed++;
    rst = 1'b0;
    repeat (BPS / 2 - 2 + 4 * BPS + BPS) @(negedge clk);
    checks++; if (done_cnt[0] !== d0) $display("FAIL rstmid_no_done got=%0d exp=0", done_cnt[0] - d0); else passed++;
    checks++; if (ferr_cnt[0] !== f0) $display("FAIL rstmid_no_ferr got=%0d exp=0", ferr_cnt[0] - f0); else passed++;
    send_frame(0, 8'h5A, 1'b0, 1'b1, 1'b1);
    wait_drain("rstmid");
    repeat (2) @(negedge clk);
    checks++; if (done_cnt[0] - d0 !== 1) $display("FAIL rstmid_next_done got=%0d exp=1", done_cnt[0] - d0); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_break();
    test_glitch();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
